// File: rtl/writeback_stage.sv
// rv32 writeback stage: in-order result queue feeding the register-file write port and decode bypass.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_result,
  input  logic              in_reg_write,
  input  logic              in_is_load,
  input  logic [2:0]        in_funct3,
  input  logic [1:0]        in_addr_lo,
  input  logic              wb_stall,
  output logic [XLEN-1:0]   write_data,
  output logic [4:0]        write_destination,
  output logic              write_enable,
  input  logic [4:0]        query_rs1,
  input  logic [4:0]        query_rs2,
  output logic              hit1,
  output logic              hit2,
  output logic [XLEN-1:0]   hit_data1,
  output logic [XLEN-1:0]   hit_data2,
  output logic [63:0]       instret
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] raw,
                                               input logic [2:0]      f3,
                                               input logic [1:0]      lo);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [XLEN-1:0]    r;
    case (lo)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = lo[1] ? raw[31:16] : raw[15:0];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = raw;
    endcase
    return r;
  endfunction

  logic [PTR_W-1:0] rd_ptr, wr_ptr, bypass_idx;
  logic [CNT_W-1:0] count;
  logic             not_full, not_empty, push, pop;
  logic [XLEN-1:0]  fmt_p0;

  logic [XLEN-1:0]  ent_data_p1 [DEPTH];
  logic [4:0]       ent_rd_p1   [DEPTH];
  logic             ent_we_p1   [DEPTH];

  logic             hit1_c, hit2_c;
  logic [XLEN-1:0]  hd1_c, hd2_c;

  assign not_full  = (count != CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign push      = reset && in_valid && not_full;
  assign pop       = reset && not_empty && !wb_stall;

  assign fmt_p0 = in_is_load ? fmt_load(in_result, in_funct3, in_addr_lo) : in_result;

  // stage 0 -> 1: formatted result enters the queue
  always_ff @(posedge clock) begin
    if (push) begin
      ent_data_p1[wr_ptr] <= fmt_p0;
      ent_rd_p1[wr_ptr]   <= in_rd;
      ent_we_p1[wr_ptr]   <= in_reg_write;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest match wins the bypass.
  always_comb begin
    hit1_c     = 1'b0;
    hit2_c     = 1'b0;
    hd1_c      = '0;
    hd2_c      = '0;
    bypass_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bypass_idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && ent_we_p1[bypass_idx] && (ent_rd_p1[bypass_idx] != 5'd0)) begin
        if (ent_rd_p1[bypass_idx] == query_rs1) begin
          hit1_c = 1'b1;
          hd1_c  = ent_data_p1[bypass_idx];
        end
        if (ent_rd_p1[bypass_idx] == query_rs2) begin
          hit2_c = 1'b1;
          hd2_c  = ent_data_p1[bypass_idx];
        end
      end
    end
  end

  // stage 1 -> register file: head drives the write port combinationally
  assign in_ready          = !reset || not_full;
  assign write_enable      = pop && ent_we_p1[rd_ptr] && (ent_rd_p1[rd_ptr] != 5'd0);
  assign write_data        = (reset && not_empty) ? ent_data_p1[rd_ptr] : '0;
  assign write_destination = (reset && not_empty) ? ent_rd_p1[rd_ptr] : 5'd0;
  assign hit1              = reset && hit1_c;
  assign hit2              = reset && hit2_c;
  assign hit_data1         = (reset && hit1_c) ? hd1_c : '0;
  assign hit_data2         = (reset && hit2_c) ? hd2_c : '0;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clock) begin
    if (!reset)   instret_q <= 64'd0;
    else if (pop) instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule
